// File: rtl/csa_accumulator_20_bit_pkg.sv
// rtl/csa_accumulator_20_bit_pkg.sv - shared widths and FSM encoding for the carry-save accumulator
package csa_pkg;

  localparam int IN_W       = 16;
  localparam int OUT_W      = 20;
  localparam int N_OPERANDS = 16;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/csa_accumulator_20_bit_if.sv
// rtl/csa_accumulator_20_bit_if.sv - operand stream and result handshake bundle
interface csa_accumulator_20_bit_if;
  import csa_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic [OUT_W-1:0] out_carry;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );

endinterface

// File: rtl/csa_3to2_20_bit.sv
// rtl/csa_3to2_20_bit.sv - combinational 3:2 compressor row; carry output is pre-shifted left by one
module csa_3to2_20_bit
  import csa_pkg::*;
(
  input  logic [OUT_W-1:0] x_i,
  input  logic [OUT_W-1:0] y_i,
  input  logic [OUT_W-1:0] z_i,
  output logic [OUT_W-1:0] s_o,
  output logic [OUT_W-1:0] c_o
);

  logic [OUT_W-2:0] maj;

  assign s_o = x_i ^ y_i ^ z_i;
  // Top majority bit would shift out of the OUT_W window, so it is never formed.
  assign maj = (x_i[OUT_W-2:0] & y_i[OUT_W-2:0]) |
               (x_i[OUT_W-2:0] & z_i[OUT_W-2:0]) |
               (y_i[OUT_W-2:0] & z_i[OUT_W-2:0]);
  assign c_o = {maj, 1'b0};

endmodule

// File: rtl/csa_accumulator_20_bit.sv
// rtl/csa_accumulator_20_bit.sv - frame-based carry-save accumulator feeding the 20-bit CLA
// CSA_ACC_SIGNED_EN: sign-extend operands (two's complement) instead of zero-extending.
module csa_accumulator_20_bit
  import csa_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  csa_accumulator_20_bit_if.slave   bus
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic [OUT_W-1:0] carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             live_q;

  logic [OUT_W-1:0] operand;
  logic [OUT_W-1:0] row_sum;
  logic [OUT_W-1:0] row_carry;
  logic [CNT_W-1:0] count_inc;
  logic             accept;
  logic             closing;

`ifdef CSA_ACC_SIGNED_EN
  assign operand = {{(OUT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
`else
  assign operand = {{(OUT_W-IN_W){1'b0}}, bus.in_data};
`endif

  csa_3to2_20_bit u_row (
    .x_i (sum_q),
    .y_i (carry_q),
    .z_i (operand),
    .s_o (row_sum),
    .c_o (row_carry)
  );

  // live_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready  = live_q && (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
  assign bus.out_count = count_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign count_inc = count_q + CNT_W'(1);
  assign closing   = bus.in_last || (count_inc == CNT_W'(N_OPERANDS));

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          sum_d   = row_sum;
          carry_d = row_carry;
          count_d = count_inc;
          state_d = closing ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          sum_d   = '0;
          carry_d = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sum_d   = '0;
        carry_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csa_accumulator_20_bit.sv
// tb/tb_csa_accumulator_20_bit.sv - directed-vector bench for the carry-save accumulator
module tb_csa_accumulator_20_bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  csa_accumulator_20_bit_if bus ();

  csa_accumulator_20_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] total();
    logic [19:0] t;
    t = bus.out_sum + bus.out_carry;
    return {12'h0, t};
  endfunction

  task automatic send(input logic [15:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 16'h0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_sum, input logic [31:0] exp_cnt);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
    check_eq({tag, "_sum"}, total(), exp_sum);
    check_eq({tag, "_count"}, {27'h0, bus.out_count}, exp_cnt);
    check_eq({tag, "_inrdy"}, {31'h0, bus.in_ready}, 32'h0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("rst_inrdy", {31'h0, bus.in_ready}, 32'h0);
    check_eq("rst_sum",   {12'h0, bus.out_sum}, 32'h0);
    check_eq("rst_carry", {12'h0, bus.out_carry}, 32'h0);
    check_eq("rst_count", {27'h0, bus.out_count}, 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_inrdy_pre", {31'h0, bus.in_ready}, 32'h0);
    @(negedge clk);
    check_eq("rel_inrdy_post", {31'h0, bus.in_ready}, 32'h1);

    // Frame 1, 2, 3
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b1);
    check_result("f123", 32'h00006, 32'd3);
    release_result();
    check_eq("f123_idle_inrdy", {31'h0, bus.in_ready}, 32'h1);
    check_eq("f123_idle_sum", {12'h0, bus.out_sum}, 32'h0);

    // Sixteen full-scale operands, no in_last
    for (int i = 0; i < 15; i++) send(16'hFFFF, 1'b0);
    @(negedge clk);
    check_eq("f16_open_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("f16_open_count", {27'h0, bus.out_count}, 32'd15);
    send(16'hFFFF, 1'b0);
    check_result("f16", 32'hFFFF0, 32'd16);

    // Backpressure with a stray operand offered during HOLD
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", {31'h0, bus.out_valid}, 32'h1);
      check_eq("bp_inrdy", {31'h0, bus.in_ready}, 32'h0);
      check_eq("bp_sum", total(), 32'hFFFF0);
      check_eq("bp_count", {27'h0, bus.out_count}, 32'd16);
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_rel_inrdy", {31'h0, bus.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_idle_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("bp_idle_inrdy", {31'h0, bus.in_ready}, 32'h1);
    check_eq("bp_idle_count", {27'h0, bus.out_count}, 32'h0);

    // Gaps inside a frame
    send(16'h0010, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("gap_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("gap_inrdy", {31'h0, bus.in_ready}, 32'h1);
    check_eq("gap_count", {27'h0, bus.out_count}, 32'd1);
    send(16'h0020, 1'b1);
    check_result("gap", 32'h00030, 32'd2);
    release_result();

    // Reset mid-frame
    send(16'h1234, 1'b0);
    send(16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("mrst_inrdy", {31'h0, bus.in_ready}, 32'h0);
    check_eq("mrst_sum",   {12'h0, bus.out_sum}, 32'h0);
    check_eq("mrst_carry", {12'h0, bus.out_carry}, 32'h0);
    check_eq("mrst_count", {27'h0, bus.out_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0005, 1'b1);
    check_result("post_rst", 32'h00005, 32'd1);
    release_result();

    // Sign handling
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
`ifdef CSA_ACC_SIGNED_EN
    check_result("signed", 32'h00001, 32'd2);
`else
    check_result("unsigned", 32'h10001, 32'd2);
`endif
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
